// File: rtl/ram_stream_reader_pkg.sv
// Shared NPU widths and the issue-credit helper used by the
// scratchpad stream reader.
package ram_stream_reader_pkg;

  localparam int unsigned NPU_DATA_WIDTH = 32;
  localparam int unsigned NPU_ADDR_WIDTH = 12;
  localparam int unsigned RSR_LEN_WIDTH  = 12;

  // A new read may issue only if the word it returns is
  // guaranteed a FIFO slot in the cycle it lands.
  function automatic logic credit_ok(
    input logic [1:0] occ,
    input logic       inflight,
    input logic       pop
  );
    logic [2:0] c;
    c = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    return c < 3'd2;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream with a last marker.
interface ram_stream_reader_if #(
  parameter int unsigned DW = 32
);
  logic                 valid;
  logic                 ready;
  logic signed [DW-1:0] data;
  logic                 last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/ram_stream_reader_fifo.sv
// Two-entry synchronous FIFO of {last, data} stream words.
module stream_fifo2 #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic [1:0]   occ_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   occ_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (occ_q == 2'd0);
  assign full_o  = (occ_q == 2'd2);
  assign occ_o   = occ_q;
  assign rdata_o = mem_q[rd_q];

  // A full FIFO still takes a push when it pops the same slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Strided scratchpad read engine: one RAM read per cycle,
// credit-limited into a 2-entry buffer feeding a word stream.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NPU_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = NPU_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = RSR_LEN_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [ADDR_WIDTH-1:0]        cfg_base,
  input  logic [ADDR_WIDTH-1:0]        cfg_stride,
  input  logic [LEN_WIDTH-1:0]         cfg_count,
  output logic                         ram_read_req,
  output logic [ADDR_WIDTH-1:0]        ram_read_addr,
  input  logic signed [DATA_WIDTH-1:0] ram_read_data,
  ram_stream_reader_if.master          out,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  inflight_q;
  logic                  infl_last_q;
  logic                  done_q;

  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [1:0]            occ;
  logic                  empty;
  logic                  unused_full;
  logic                  pop;
  logic                  req;
  logic                  req_last;

  stream_fifo2 #(
    .W (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .wdata_i ({infl_last_q, ram_read_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .occ_o   (occ),
    .empty_o (empty),
    .full_o  (unused_full)
  );

  assign out.valid = ~empty;
  assign out.data  = fifo_rdata[DATA_WIDTH-1:0];
  assign out.last  = fifo_rdata[DATA_WIDTH];
  assign pop       = out.valid & out.ready;

  assign req_last = (remain_q == LEN_WIDTH'(1));
  assign req      = (state_q == S_RUN)
                 && credit_ok(occ, inflight_q, pop);

  assign ram_read_req  = req;
  assign ram_read_addr = addr_q;
  assign cfg_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      inflight_q  <= req;
      infl_last_q <= req & req_last;
      unique case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            addr_q   <= cfg_base;
            stride_q <= cfg_stride;
            remain_q <= cfg_count;
            if (cfg_count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (req) begin
            remain_q <= remain_q - LEN_WIDTH'(1);
            // Keep the final address on the bus after the last issue.
            if (req_last) begin
              state_q <= S_DRAIN;
            end else begin
              addr_q <= addr_q + stride_q;
            end
          end
        end
        S_DRAIN: begin
          if (pop && out.last) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 1-cycle RAM model.
module tb_ram_stream_reader;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_stride = '0;
  logic [LW-1:0] cfg_count = '0;
  logic          ram_req;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data = '0;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] exp_addr [8];

  ram_stream_reader_if #(.DW(DW)) s_if ();

  ram_stream_reader dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_base      (cfg_base),
    .cfg_stride    (cfg_stride),
    .cfg_count     (cfg_count),
    .ram_read_req  (ram_req),
    .ram_read_addr (ram_addr),
    .ram_read_data (ram_data),
    .out           (s_if),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // RAM contents: mem[a] = a, one-cycle registered read.
  always @(posedge clk) begin
    if (ram_req) ram_data <= {{(DW-AW){1'b0}}, ram_addr};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_valid = 1'b0;
    s_if.ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready);
    end
    n_tests++;
    if (s_if.valid !== 1'b0 || s_if.last !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b/%b want 0/0", s_if.valid, s_if.last);
    end
    n_tests++;
    if (s_if.data !== '0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", s_if.data);
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_done got %b/%b want 0/0", busy, done);
    end
    n_tests++;
    if (ram_req !== 1'b0 || ram_addr !== '0) begin
      n_fail++; $display("FAIL reset_ram got %b/%h want 0/0", ram_req, ram_addr);
    end
  endtask

  // Full-rate job with out_ready=1; exp_addr holds the address list.
  task automatic run_full_rate(input string nm, input logic [AW-1:0] b,
                               input logic [AW-1:0] s, input int cnt);
    logic exp_req, exp_v;
    logic [DW-1:0] exp_d;
    int oi;
    tick();
    cfg_base = b;
    cfg_stride = s;
    cfg_count = LW'(cnt);
    cfg_valid = 1'b1;
    s_if.ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s hs_ready got %b want 1", nm, cfg_ready);
    end
    for (int k = 1; k <= cnt + 3; k++) begin
      tick();
      cfg_valid = 1'b0;
      @(negedge clk);
      exp_req = (k <= cnt);
      n_tests++;
      if (ram_req !== exp_req) begin
        n_fail++; $display("FAIL %s req k=%0d got %b want %b", nm, k, ram_req, exp_req);
      end
      if (exp_req) begin
        n_tests++;
        if (ram_addr !== exp_addr[k-1]) begin
          n_fail++;
          $display("FAIL %s addr k=%0d got %0d want %0d", nm, k, ram_addr, exp_addr[k-1]);
        end
      end
      exp_v = (k >= 3) && (k <= cnt + 2);
      n_tests++;
      if (s_if.valid !== exp_v) begin
        n_fail++; $display("FAIL %s valid k=%0d got %b want %b", nm, k, s_if.valid, exp_v);
      end
      if (exp_v) begin
        oi = k - 3;
        exp_d = {{(DW-AW){1'b0}}, exp_addr[oi]};
        n_tests++;
        if (s_if.data !== exp_d || s_if.last !== (oi == cnt - 1)) begin
          n_fail++;
          $display("FAIL %s data k=%0d got %0d/%b want %0d/%b",
                   nm, k, s_if.data, s_if.last, exp_d, oi == cnt - 1);
        end
      end
      n_tests++;
      if (done !== (k == cnt + 3)) begin
        n_fail++; $display("FAIL %s done k=%0d got %b want %b", nm, k, done, k == cnt + 3);
      end
      n_tests++;
      if (busy !== (k <= cnt + 2) || cfg_ready !== (k > cnt + 2)) begin
        n_fail++;
        $display("FAIL %s busy k=%0d got %b/%b want %b", nm, k, busy, cfg_ready, k <= cnt + 2);
      end
    end
  endtask

  task automatic test_basic_stream();
    for (int i = 0; i < 4; i++) exp_addr[i] = AW'(4 + i);
    run_full_rate("basic", 12'd4, 12'd1, 4);
  endtask

  task automatic test_stride_wrap();
    exp_addr[0] = 12'd4094;
    exp_addr[1] = 12'd1;
    exp_addr[2] = 12'd4;
    run_full_rate("wrap", 12'd4094, 12'd3, 3);
  endtask

  task automatic test_backpressure();
    int occ_m, infl_m, issued, pops;
    logic exp_req, pop, prev_stall, last_prev, seen_done;
    logic [DW:0] prev_word;
    logic [DW-1:0] exp_d;
    occ_m = 0; infl_m = 0; issued = 0; pops = 0;
    prev_stall = 1'b0; last_prev = 1'b0; seen_done = 1'b0;
    prev_word = '0;
    tick();
    cfg_base = 12'd16;
    cfg_stride = 12'd2;
    cfg_count = 12'd8;
    cfg_valid = 1'b1;
    s_if.ready = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 60 && !seen_done; k++) begin
      tick();
      cfg_valid = 1'b0;
      s_if.ready = (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
      @(negedge clk);
      pop = s_if.valid & s_if.ready;
      exp_req = (issued < 8) && ((occ_m + infl_m - int'(pop)) < 2);
      n_tests++;
      if (ram_req !== exp_req) begin
        n_fail++;
        $display("FAIL bp_req k=%0d got %b want %b occ=%0d infl=%0d",
                 k, ram_req, exp_req, occ_m, infl_m);
      end
      if (ram_req === 1'b1) begin
        n_tests++;
        if (ram_addr !== AW'(16 + 2 * issued)) begin
          n_fail++; $display("FAIL bp_addr k=%0d got %0d want %0d", k, ram_addr, 16 + 2 * issued);
        end
      end
      n_tests++;
      if (s_if.valid !== (occ_m > 0) || occ_m + infl_m > 2) begin
        n_fail++; $display("FAIL bp_valid k=%0d got %b want %b", k, s_if.valid, occ_m > 0);
      end
      if (prev_stall) begin
        n_tests++;
        if (s_if.valid !== 1'b1 || {s_if.last, s_if.data} !== prev_word) begin
          n_fail++; $display("FAIL bp_stable k=%0d got %h want %h", k, {s_if.last, s_if.data}, prev_word);
        end
      end
      if (pop) begin
        exp_d = DW'(16 + 2 * pops);
        n_tests++;
        if (pops >= 8 || s_if.data !== exp_d || s_if.last !== (pops == 7)) begin
          n_fail++;
          $display("FAIL bp_word n=%0d got %0d/%b want %0d/%b", pops, s_if.data, s_if.last, exp_d, pops == 7);
        end
        pops++;
      end
      n_tests++;
      if (done !== last_prev) begin
        n_fail++; $display("FAIL bp_done k=%0d got %b want %b", k, done, last_prev);
      end
      if (done === 1'b1) seen_done = 1'b1;
      occ_m = occ_m + infl_m - int'(pop);
      infl_m = int'(ram_req === 1'b1);
      issued += int'(ram_req === 1'b1);
      prev_stall = s_if.valid & ~s_if.ready;
      prev_word = {s_if.last, s_if.data};
      last_prev = pop & s_if.last;
    end
    n_tests++;
    if (!seen_done || pops != 8 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_end got done=%b pops=%0d busy=%b want 1/8/0", seen_done, pops, busy);
    end
  endtask

  task automatic test_empty_job();
    tick();
    cfg_base = 12'd55;
    cfg_stride = 12'd1;
    cfg_count = 12'd0;
    cfg_valid = 1'b1;
    s_if.ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL empty_hs got %b/%b want 1/0", cfg_ready, busy);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      cfg_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (done !== (k == 1)) begin
        n_fail++; $display("FAIL empty_done k=%0d got %b want %b", k, done, k == 1);
      end
      n_tests++;
      if (ram_req !== 1'b0 || s_if.valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL empty_idle k=%0d got req=%b v=%b busy=%b rdy=%b want 0/0/0/1",
                 k, ram_req, s_if.valid, busy, cfg_ready);
      end
    end
  endtask

  task automatic test_abort();
    tick();
    cfg_base = 12'd100;
    cfg_stride = 12'd1;
    cfg_count = 12'd6;
    cfg_valid = 1'b1;
    s_if.ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      tick();
      cfg_valid = 1'b0;
      @(negedge clk);
      if (k >= 3) begin
        n_tests++;
        if (s_if.valid !== 1'b1 || s_if.data !== DW'(100 + k - 3)) begin
          n_fail++; $display("FAIL abort_pre k=%0d got %b/%0d want 1/%0d", k, s_if.valid, s_if.data, 100 + k - 3);
        end
      end
    end
    tick();
    reset = 1'b1;
    s_if.ready = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b0;
    s_if.ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (s_if.valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state got v=%b busy=%b rdy=%b done=%b want 0/0/1/0",
               s_if.valid, busy, cfg_ready, done);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || s_if.valid !== 1'b0 || ram_req !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet k=%0d got d=%b v=%b r=%b want 0/0/0", k, done, s_if.valid, ram_req);
      end
    end
    exp_addr[0] = 12'd200;
    exp_addr[1] = 12'd205;
    run_full_rate("abort_next", 12'd200, 12'd5, 2);
  endtask

  task automatic test_cfg_while_busy();
    logic [DW-1:0] exp_w [5];
    int hs, pops, dones;
    logic drop;
    exp_w = '{32'd40, 32'd41, 32'd42, 32'd300, 32'd307};
    hs = 0; pops = 0; dones = 0; drop = 1'b0;
    tick();
    cfg_base = 12'd40;
    cfg_stride = 12'd1;
    cfg_count = 12'd3;
    cfg_valid = 1'b1;
    s_if.ready = 1'b1;
    @(negedge clk);
    if (cfg_ready === 1'b1) hs = 1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) begin
        cfg_base = 12'd300;
        cfg_stride = 12'd7;
        cfg_count = 12'd2;
      end
      if (drop) cfg_valid = 1'b0;
      @(negedge clk);
      if (busy === 1'b1) begin
        n_tests++;
        if (cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL busy_cfg_ready k=%0d got %b want 0", k, cfg_ready);
        end
      end
      if (cfg_valid && cfg_ready === 1'b1) begin
        hs++;
        drop = 1'b1;
        n_tests++;
        if (done !== 1'b1) begin
          n_fail++; $display("FAIL busy_accept_done k=%0d got %b want 1", k, done);
        end
      end
      if (s_if.valid === 1'b1) begin
        n_tests++;
        if (pops >= 5 || s_if.data !== exp_w[pops]) begin
          n_fail++; $display("FAIL busy_word n=%0d got %0d want %0d", pops, s_if.data, exp_w[pops % 5]);
        end
        pops++;
      end
      if (done === 1'b1) dones++;
    end
    n_tests++;
    if (hs != 2 || pops != 5 || dones != 2) begin
      n_fail++; $display("FAIL busy_totals got hs=%0d pops=%0d dones=%0d want 2/5/2", hs, pops, dones);
    end
  endtask

  initial begin
    s_if.ready = 1'b0;
    test_reset();
    test_basic_stream();
    test_stride_wrap();
    test_backpressure();
    test_empty_job();
    test_abort();
    test_cfg_while_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
